// File: rtl/lvds_capture_pkg.sv
// Shared definitions for the LVDS capture sequencer: state encoding,
// default buffer length and the saturation limit of the dropped-start counter.
package lvds_capture_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

  localparam int         BUFFER_SIZE_DEFAULT = 4096;
  localparam logic [7:0] DROP_CNT_MAX        = 8'd255;

endpackage

// File: rtl/toggle_sync.sv
// Brings a request toggle from the AXI domain into LVDS_CLK and turns each
// edge of it into a single-cycle pulse.
module toggle_sync
  import lvds_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic LVDS_CLK,
  input  logic lvds_resetn,
  input  logic tgl,
  output logic pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Shift the toggle through the synchronizer chain and keep the last settled level.
  always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
    if (!lvds_resetn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tgl};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign pulse = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/lvds_capture_seq.sv
// Capture sequencer: accepts start/abort toggles, optionally waits for a
// rising edge on one lane, then streams one buffer length of lane samples
// to the lane buffers and reports completion with a toggle.
module lvds_capture_seq
  import lvds_capture_pkg::*;
#(
  parameter int BUFFER_SIZE = BUFFER_SIZE_DEFAULT,
  parameter int ADDR_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic              LVDS_CLK,
  input  logic              lvds_resetn,
  input  logic              start_tgl,
  input  logic              abort_tgl,
  input  logic              trig_en,
  input  logic [1:0]        trig_lane,
  input  logic [3:0]        lvds_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [3:0]        wr_data,
  output logic              busy,
  output logic              done_tgl,
  output logic              aborted,
  output logic [7:0]        start_drop_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BUFFER_SIZE - 1);

  logic [3:0]        lvds_q, lvds_qq;
  logic              start_pulse, abort_pulse, trigger;
  cap_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        trig_lane_q, trig_lane_d;
  logic              aborted_d;
  logic [7:0]        drop_d;

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_start_sync (
    .LVDS_CLK    (LVDS_CLK),
    .lvds_resetn (lvds_resetn),
    .tgl         (start_tgl),
    .pulse       (start_pulse)
  );

  toggle_sync #(.SYNC_STAGES(SYNC_STAGES)) u_abort_sync (
    .LVDS_CLK    (LVDS_CLK),
    .lvds_resetn (lvds_resetn),
    .tgl         (abort_tgl),
    .pulse       (abort_pulse)
  );

  // Register the raw lanes once for capture and a second time for edge detection.
  always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
    if (!lvds_resetn) begin
      lvds_q  <= '0;
      lvds_qq <= '0;
    end else begin
      lvds_q  <= lvds_in;
      lvds_qq <= lvds_q;
    end
  end

  assign trigger = lvds_q[trig_lane_q] & ~lvds_qq[trig_lane_q];

  // Sequencer state, write address counter and the lane chosen at start.
  always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
    if (!lvds_resetn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      trig_lane_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      trig_lane_q <= trig_lane_d;
    end
  end

  // Next-state decode; trig_en only steers the IDLE exit, so it is used as sampled there.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    trig_lane_d = trig_lane_q;
    aborted_d   = aborted;
    drop_d      = start_drop_cnt;
    if (start_pulse && (state_q != IDLE) && (start_drop_cnt != DROP_CNT_MAX)) begin
      drop_d = start_drop_cnt + 8'd1;
    end
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          trig_lane_d = trig_lane;
          aborted_d   = 1'b0;
          addr_d      = '0;
          state_d     = trig_en ? ARM : CAPTURE;
        end
      end
      ARM: begin
        if (abort_pulse) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (trigger) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        if (abort_pulse) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q == LAST_ADDR) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs: writes trail the CAPTURE state by one cycle, busy tracks the state itself.
  always_ff @(posedge LVDS_CLK or negedge lvds_resetn) begin
    if (!lvds_resetn) begin
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      busy           <= 1'b0;
      done_tgl       <= 1'b0;
      aborted        <= 1'b0;
      start_drop_cnt <= '0;
    end else begin
      wr_en          <= (state_q == CAPTURE);
      wr_addr        <= addr_q;
      wr_data        <= (state_q == CAPTURE) ? lvds_q : 4'd0;
      busy           <= (state_d == ARM) || (state_d == CAPTURE);
      aborted        <= aborted_d;
      start_drop_cnt <= drop_d;
      if (state_q == DONE) begin
        done_tgl <= ~done_tgl;
      end
    end
  end

endmodule

// File: tb/tb_lvds_capture_seq.sv
// Self-checking bench for lvds_capture_seq: table-driven capture scenarios
// with random lane data, plus hand-written sequences for simultaneous
// requests, counter saturation and reset in the middle of a capture.
module tb_lvds_capture_seq;
  import lvds_capture_pkg::*;

  localparam int BUF  = 4096;
  localparam int AW   = 12;
  localparam int SYNC = 2;

  logic          LVDS_CLK = 1'b0;
  logic          lvds_resetn = 1'b0;
  logic          start_tgl = 1'b0;
  logic          abort_tgl = 1'b0;
  logic          trig_en = 1'b0;
  logic [1:0]    trig_lane = 2'd0;
  logic [3:0]    lvds_in = 4'd0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          busy;
  logic          done_tgl;
  logic          aborted;
  logic [7:0]    start_drop_cnt;

  lvds_capture_seq #(.BUFFER_SIZE(BUF), .ADDR_W(AW), .SYNC_STAGES(SYNC)) dut (
    .LVDS_CLK       (LVDS_CLK),
    .lvds_resetn    (lvds_resetn),
    .start_tgl      (start_tgl),
    .abort_tgl      (abort_tgl),
    .trig_en        (trig_en),
    .trig_lane      (trig_lane),
    .lvds_in        (lvds_in),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .busy           (busy),
    .done_tgl       (done_tgl),
    .aborted        (aborted),
    .start_drop_cnt (start_drop_cnt)
  );

  always #5 LVDS_CLK = ~LVDS_CLK;

  typedef struct {
    logic       te;
    logic [1:0] lane;
    int         trig_delay;
    int         abort_at;
    int         extra_starts;
    int         exp_writes;
    int         exp_aborted;
    int         exp_flips;
  } vec_t;

  vec_t       vecs [6];
  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  logic [3:0] in_hist [65536];
  logic [3:0] set_mask = 4'd0;
  logic [3:0] clr_mask = 4'd0;

  // Capture monitor: what the buffers would have received during one scenario.
  int   wr_count, first_wr, last_wr, bad_addr, bad_data, done_flips, done_tick, busy_mid;
  logic prev_done;

  // Reference state kept by the bench itself.
  int   exp_drop = 0;
  logic exp_done = 1'b0;

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearMon();
    wr_count = 0; first_wr = -1; last_wr = -1; bad_addr = 0; bad_data = 0;
    done_flips = 0; done_tick = -1; busy_mid = -1; prev_done = done_tgl;
  endtask

  task automatic tick();
    in_hist[(cyc + 1) % 65536] = lvds_in;
    @(posedge LVDS_CLK);
    #1;
    cyc++;
  endtask

  task automatic step();
    lvds_in = (4'($urandom) & ~clr_mask) | set_mask;
    tick();
    if (wr_en) begin
      if (wr_count == 0) first_wr = cyc;
      if (int'(wr_addr) != wr_count) bad_addr++;
      if (wr_data !== in_hist[(cyc - 1) % 65536]) bad_data++;
      wr_count++;
      last_wr = cyc;
      if (wr_count == 2000) busy_mid = int'(busy);
    end
    if (done_tgl !== prev_done) begin
      done_flips++;
      done_tick = cyc;
      prev_done = done_tgl;
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_wr_en"},   int'(wr_en),          0);
    checkOutput({tag, "_wr_addr"}, int'(wr_addr),        0);
    checkOutput({tag, "_wr_data"}, int'(wr_data),        0);
    checkOutput({tag, "_busy"},    int'(busy),           0);
    checkOutput({tag, "_done"},    int'(done_tgl),       0);
    checkOutput({tag, "_aborted"}, int'(aborted),        0);
    checkOutput({tag, "_drops"},   int'(start_drop_cnt), 0);
  endtask

  task automatic checkCapture(input string tag, input int exp_writes, input int exp_ab, input int exp_flips);
    checkOutput({tag, "_writes"},  wr_count, exp_writes);
    checkOutput({tag, "_gapless"}, last_wr - first_wr + 1, wr_count);
    checkOutput({tag, "_badaddr"}, bad_addr, 0);
    checkOutput({tag, "_baddata"}, bad_data, 0);
    checkOutput({tag, "_flips"},   done_flips, exp_flips);
    if (exp_flips == 1) checkOutput({tag, "_donetick"}, done_tick, last_wr + 1);
    if (exp_writes >= 2000) checkOutput({tag, "_busymid"}, busy_mid, 1);
    checkOutput({tag, "_aborted"}, int'(aborted), exp_ab);
    checkOutput({tag, "_busyend"}, int'(busy), 0);
    checkOutput({tag, "_drops"},   int'(start_drop_cnt), exp_drop);
    checkOutput({tag, "_donetgl"}, int'(done_tgl), int'(exp_done));
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    int t0, arrival, exp_first;
    bit abort_sent;
    string tag;
    tag        = $sformatf("v%0d", idx);
    trig_en    = v.te;
    trig_lane  = v.lane;
    clr_mask   = v.te ? (4'b0001 << v.lane) : 4'b0000;
    set_mask   = 4'b0000;
    clearMon();
    t0         = cyc;
    arrival    = -1;
    abort_sent = 1'b0;
    start_tgl  = ~start_tgl;
    for (int s = 0; s < v.trig_delay + BUF + 24; s++) begin
      if (v.te && s == v.trig_delay) begin
        clr_mask = 4'b0000;
        set_mask = 4'b0001 << v.lane;
        arrival  = cyc;
      end
      if (v.te && s == v.trig_delay + 3) set_mask = 4'b0000;
      step();
      if (wr_en && v.abort_at > 0 && !abort_sent && wr_count == v.abort_at) begin
        abort_tgl  = ~abort_tgl;
        abort_sent = 1'b1;
      end
      if (wr_en && ((wr_count == 500 && v.extra_starts > 0) ||
                    (wr_count == 1500 && v.extra_starts > 1) ||
                    (wr_count == 2500 && v.extra_starts > 2))) begin
        start_tgl = ~start_tgl;
      end
    end
    exp_first = v.te ? arrival + 3 : t0 + SYNC + 2;
    exp_drop  = sat255(exp_drop + v.extra_starts);
    exp_done  = exp_done ^ v.exp_flips[0];
    checkOutput({tag, "_firstwr"}, first_wr, exp_first);
    checkCapture(tag, v.exp_writes, v.exp_aborted, v.exp_flips);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int t0;
    int n_sent;
    bit sent;

    vecs[0] = '{te:1'b0, lane:2'd0, trig_delay:0,   abort_at:0,    extra_starts:0, exp_writes:BUF,  exp_aborted:0, exp_flips:1};
    vecs[1] = '{te:1'b1, lane:2'd2, trig_delay:100, abort_at:0,    extra_starts:0, exp_writes:BUF,  exp_aborted:0, exp_flips:1};
    vecs[2] = '{te:1'b0, lane:2'd0, trig_delay:0,   abort_at:1000, extra_starts:0, exp_writes:1003, exp_aborted:1, exp_flips:0};
    vecs[3] = '{te:1'b0, lane:2'd1, trig_delay:0,   abort_at:0,    extra_starts:0, exp_writes:BUF,  exp_aborted:0, exp_flips:1};
    vecs[4] = '{te:1'b0, lane:2'd0, trig_delay:0,   abort_at:0,    extra_starts:3, exp_writes:BUF,  exp_aborted:0, exp_flips:1};
    vecs[5] = '{te:1'b1, lane:2'd0, trig_delay:37,  abort_at:50,   extra_starts:0, exp_writes:53,   exp_aborted:1, exp_flips:0};

    #2;
    checkReset("por");
    repeat (3) @(posedge LVDS_CLK);
    #1;
    lvds_resetn = 1'b1;
    for (int i = 0; i < 8; i++) step();
    checkOutput("idle_busy", int'(busy), 0);

    for (int i = 0; i < 6; i++) applyStimulus(i, vecs[i]);

    // Start and abort together while idle: the start wins.
    trig_en = 1'b0; clr_mask = 4'd0; set_mask = 4'd0;
    clearMon();
    start_tgl = ~start_tgl;
    abort_tgl = ~abort_tgl;
    for (int s = 0; s < 3; s++) step();
    checkOutput("simidle_busy", int'(busy), 1);
    for (int s = 0; s < BUF + 20; s++) step();
    exp_done = ~exp_done;
    checkCapture("simidle", BUF, 0, 1);

    // Start and abort together mid-capture: abort wins, start counted as dropped.
    clearMon();
    sent = 1'b0;
    start_tgl = ~start_tgl;
    for (int s = 0; s < BUF + 24; s++) begin
      step();
      if (wr_en && !sent && wr_count == 300) begin
        start_tgl = ~start_tgl;
        abort_tgl = ~abort_tgl;
        sent = 1'b1;
      end
    end
    exp_drop = sat255(exp_drop + 1);
    checkCapture("simcap", 303, 1, 0);

    // 300 dropped starts during one capture: the counter pins at 255.
    clearMon();
    n_sent = 0;
    start_tgl = ~start_tgl;
    for (int s = 0; s < BUF + 24; s++) begin
      step();
      if (wr_count >= 100 && n_sent < 300 && (s % 3) == 0) begin
        start_tgl = ~start_tgl;
        n_sent++;
      end
    end
    exp_drop = sat255(exp_drop + 300);
    exp_done = ~exp_done;
    checkOutput("sat_sent", n_sent, 300);
    checkCapture("sat", BUF, 0, 1);

    // Reset in the middle of a capture: outputs clear without waiting for a clock.
    clearMon();
    start_tgl = ~start_tgl;
    t0 = cyc;
    while (wr_count < 2001 && cyc - t0 < BUF + 24) step();
    checkOutput("rst_reached", int'(wr_addr), 2000);
    lvds_resetn = 1'b0;
    start_tgl   = 1'b0;
    abort_tgl   = 1'b0;
    #1;
    checkReset("midrst");
    exp_drop = 0;
    exp_done = 1'b0;
    for (int s = 0; s < 3; s++) tick();
    lvds_resetn = 1'b1;
    clearMon();
    for (int s = 0; s < 20; s++) step();
    checkOutput("postrst_writes", wr_count, 0);
    checkOutput("postrst_busy", int'(busy), 0);
    checkOutput("postrst_drops", int'(start_drop_cnt), exp_drop);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lvds_capture_seq.md
# lvds_capture_seq

Capture sequencer for the 4-lane LVDS acquisition path, clocked entirely in the LVDS_CLK domain. It receives start/abort requests from the AXI register domain as toggles and optionally waits for a trigger edge on a selected lane. It then drives write enable, address and data into the four 4096-bit lane buffers for exactly one buffer length, and returns a completion toggle to the AXI domain. It is the sequencing half of the capture core; the buffers and the AXI register file sit outside it.

## Interface
- BUFFER_SIZE, 4096: capture length in bits per lane; power of two.
- ADDR_W, 12: buffer address width, equal to log2(BUFFER_SIZE).
- SYNC_STAGES, 2: flop count in each toggle synchronizer; minimum 2.

Ports:
- LVDS_CLK  in  1: capture clock.
- lvds_resetn  in  1: reset, asynchronous, active-low; clock LVDS_CLK.
- start_tgl  in  1: start request toggle from the AXI domain; each edge is one request.
- abort_tgl  in  1: abort request toggle from the AXI domain.
- trig_en  in  1: quasi-static; 1 means wait for a trigger before capturing.
- trig_lane  in  2: quasi-static; lane index watched for the trigger rising edge.
- lvds_in  in  4: raw lane bits.
- wr_en  out  1: buffer write enable.
- wr_addr  out  ADDR_W: buffer bit address.
- wr_data  out  4: one bit per lane buffer.
- busy  out  1: high in ARM or CAPTURE.
- done_tgl  out  1: toggles once per completed capture.
- aborted  out  1: sticky; set by an abort, cleared by the next accepted start.
- start_drop_cnt  out  8: count of start requests ignored while busy; saturates at 255.

## Operation
- Inputs: lvds_in is registered once (lvds_q), and the trigger detector registers it a second time (lvds_qq). Trigger = lvds_q[trig_lane] & ~lvds_qq[trig_lane].
- Toggle sync: each toggle passes through SYNC_STAGES flops plus one history flop. A request pulse is high for one cycle when the last sync stage differs from the history flop.
- FSM states IDLE, ARM, CAPTURE, DONE; reset state IDLE.
  - IDLE: on a start pulse, latch trig_en and trig_lane, clear aborted, clear the address counter. Go to ARM if the latched trig_en is 1, otherwise go to CAPTURE.
  - ARM: on a trigger, go to CAPTURE. The trigger cycle's sample is not written; the first written sample is the following lvds_q.
  - CAPTURE: wr_en=1 every cycle, wr_data=lvds_q, wr_addr counts 0..BUFFER_SIZE-1. The write at address BUFFER_SIZE-1 moves the FSM to DONE. The counter wraps to 0 and never exceeds BUFFER_SIZE-1.
  - DONE: one cycle. Flip done_tgl, then go to IDLE.
- Abort pulse in ARM or CAPTURE: go to IDLE next cycle, set aborted, no done_tgl flip. Buffer contents are partial. An abort in IDLE or DONE is ignored.
- Start pulse in ARM, CAPTURE or DONE: ignored; start_drop_cnt increments (saturating).
- Simultaneous start and abort pulses:
  - In IDLE, the start is accepted.
  - Otherwise, the abort wins and the start is counted as dropped.
- Configuration changes after the start is accepted have no effect until the next start.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, done_tgl=0, aborted=0, start_drop_cnt=0, FSM=IDLE, all sync flops 0.
- Outputs are registered. busy is high the cycle after the FSM leaves IDLE and low the cycle it enters IDLE.
- Start latency (trig_en=0): an edge on start_tgl produces the first wr_en no later than SYNC_STAGES+2 LVDS_CLK cycles later, excluding metastability uncertainty of ±1 cycle.
- Capture is exactly BUFFER_SIZE consecutive wr_en cycles with no gaps. done_tgl flips 1 cycle after the last wr_en.
- Trigger latency: a lane rising edge arriving at lvds_in produces the first wr_en 3 cycles later.
- Reset mid-capture: all outputs return to their reset values immediately (asynchronous). A pending toggle difference is lost, because the sync flops also reset to 0.

## Structure
- Shared package lvds_capture_pkg holds:
  - the state encoding constants (IDLE=0, ARM=1, CAPTURE=2, DONE=3);
  - the BUFFER_SIZE default;
  - the start_drop_cnt saturation value.
- Sub-module toggle_sync(SYNC_STAGES): toggle in, pulse out, clocked on LVDS_CLK, reset by lvds_resetn. It is instantiated twice (start, abort).
- The buffers stay in the top-level data-read core, written from wr_en/wr_addr/wr_data.

## Test plan
- Free-run: trig_en=0, one start_tgl edge, lvds_in = counter pattern → 4096 wr_en cycles, addresses 0..4095 in order, wr_data equals lvds_in delayed 1 cycle, done_tgl flips once, aborted=0.
- Triggered: trig_en=1, trig_lane=2, start, hold lane 2 low for 100 cycles then raise it → no wr_en before the edge; first wr_en 3 cycles after the edge; 4096 writes follow.
- Abort: start, abort_tgl edge at wr_addr≈1000 → wr_en drops within SYNC_STAGES+2 cycles, aborted=1, done_tgl unchanged; the next start clears aborted and restarts at address 0.
- Busy drops: 3 start edges during one capture → all ignored, start_drop_cnt=3, exactly one done_tgl flip. Force 300 drops → count holds at 255.
- Simultaneous events: start and abort edges on the same cycle in IDLE → capture starts. The same pair during CAPTURE → capture aborts and start_drop_cnt increments.
- Reset mid-capture: assert lvds_resetn low at wr_addr=2000 → all outputs return to reset values asynchronously. After release with no new edge, the FSM stays IDLE.
